// File: rtl/frame_blit_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_blit_scheduler_pkg
// Description : Shared constants and FSM state encoding for the frame blitter.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_blit_scheduler_pkg;

    localparam int c_FRAME_WORDS    = 1024;
    localparam int c_FRAME_SEL_BITS = 2;
    localparam int c_FS_ADDR_BITS   = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_COPY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_SKIP  = 3'd5
    } blitState_t;

endpackage
`default_nettype wire

// File: rtl/frame_blit_scheduler_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : blit_addr_gen
// Description : Copy word counter with terminal flag and a one-cycle-delayed
//               address/valid pair that tracks the write side of the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module blit_addr_gen
    import frame_blit_scheduler_pkg::*;
#(
    parameter int FRAME_WORDS = c_FRAME_WORDS,
    parameter int WORD_BITS   = $clog2(FRAME_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    output logic [WORD_BITS-1:0] o_wordIdx,
    output logic                 o_lastWord,
    output logic [WORD_BITS-1:0] o_dstAddr,
    output logic                 o_dstValid
);

    logic [WORD_BITS-1:0] r_count;
    logic [WORD_BITS-1:0] r_dstAddr;
    logic                 r_dstValid;

    // Counter rests at zero outside a copy so every copy starts at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_dstAddr  <= '0;
            r_dstValid <= 1'b0;
        end else begin
            r_count    <= i_run ? r_count + {{(WORD_BITS-1){1'b0}}, 1'b1} : '0;
            r_dstAddr  <= i_run ? r_count : '0;
            r_dstValid <= i_run;
        end
    end

    assign o_wordIdx  = r_count;
    assign o_lastWord = (r_count == WORD_BITS'(FRAME_WORDS - 1));
    assign o_dstAddr  = r_dstAddr;
    assign o_dstValid = r_dstValid;

endmodule
`default_nettype wire

// File: rtl/frame_blit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_blit_scheduler
// Description : Per-tick copy of one frame from the frame store into VRAM,
//               followed by a GPU draw pulse; ticks are skipped if GPU busy.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_blit_scheduler
    import frame_blit_scheduler_pkg::*;
#(
    parameter int FRAME_WORDS    = c_FRAME_WORDS,
    parameter int FRAME_SEL_BITS = c_FRAME_SEL_BITS
) (
    input  logic                                           CLK,
    input  logic                                           RESET,
    input  logic                                           TICK_IRQ,
    output logic                                           TICK_IACK,
    output logic                                           TICK_IEND,
    input  logic                                           SEL_VALID,
    input  logic [FRAME_SEL_BITS-1:0]                      SEL_FRAME,
    input  logic                                           SEL_AUTO,
    output logic                                           SRC_EN,
    output logic [FRAME_SEL_BITS+$clog2(FRAME_WORDS)-1:0]  SRC_ADDR,
    input  logic [15:0]                                    SRC_DATA,
    output logic                                           DST_EN,
    output logic                                           DST_WE,
    output logic [$clog2(FRAME_WORDS)-1:0]                 DST_ADDR,
    output logic [15:0]                                    DST_DATA,
    input  logic                                           GPU_READY,
    output logic                                           GPU_DRAW,
    output logic                                           BUSY,
    output logic [FRAME_SEL_BITS-1:0]                      CUR_FRAME,
    output logic [7:0]                                     SKIP_CNT
);

    localparam int c_WORD_BITS = $clog2(FRAME_WORDS);

    blitState_t                r_state;
    blitState_t                w_nextState;
    logic [FRAME_SEL_BITS-1:0] r_curFrame;
    logic [FRAME_SEL_BITS-1:0] r_copyFrame;
    logic                      r_auto;
    logic                      r_pendValid;
    logic [FRAME_SEL_BITS-1:0] r_pendFrame;
    logic                      r_pendAuto;
    logic [7:0]                r_skipCnt;

    logic                      w_run;
    logic [c_WORD_BITS-1:0]    w_wordIdx;
    logic                      w_lastWord;
    logic [c_WORD_BITS-1:0]    w_dstAddr;
    logic                      w_dstValid;
    logic                      w_applySel;

    blit_addr_gen #(
        .FRAME_WORDS (FRAME_WORDS),
        .WORD_BITS   (c_WORD_BITS)
    ) u_addrGen (
        .clk        (CLK),
        .rst        (RESET),
        .i_run      (w_run),
        .o_wordIdx  (w_wordIdx),
        .o_lastWord (w_lastWord),
        .o_dstAddr  (w_dstAddr),
        .o_dstValid (w_dstValid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        TICK_IACK   = 1'b0;
        TICK_IEND   = 1'b0;
        GPU_DRAW    = 1'b0;
        BUSY        = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (TICK_IRQ) w_nextState = ST_ACK;
            end
            ST_ACK: begin
                TICK_IACK   = 1'b1;
                BUSY        = 1'b1;
                w_nextState = GPU_READY ? ST_COPY : ST_SKIP;
            end
            ST_COPY: begin
                BUSY  = 1'b1;
                w_run = 1'b1;
                if (w_lastWord) w_nextState = ST_DRAIN;
            end
            ST_DRAIN: begin
                BUSY        = 1'b1;
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                BUSY        = 1'b1;
                GPU_DRAW    = 1'b1;
                TICK_IEND   = 1'b1;
                w_nextState = ST_IDLE;
            end
            ST_SKIP: begin
                TICK_IEND   = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // A select arriving in the same cycle as an update point takes effect at once.
    assign w_applySel = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                        (SEL_VALID || r_pendValid);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_curFrame  <= '0;
            r_copyFrame <= '0;
            r_auto      <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendFrame <= '0;
            r_pendAuto  <= 1'b0;
            r_skipCnt   <= '0;
        end else begin
            if ((r_state == ST_ACK) && GPU_READY) begin
                r_copyFrame <= r_curFrame;
            end
            if ((r_state == ST_SKIP) && (r_skipCnt != 8'hFF)) begin
                r_skipCnt <= r_skipCnt + 8'd1;
            end
            if (w_applySel) begin
                r_curFrame  <= SEL_VALID ? SEL_FRAME : r_pendFrame;
                r_auto      <= SEL_VALID ? SEL_AUTO  : r_pendAuto;
                r_pendValid <= 1'b0;
            end else begin
                if ((r_state == ST_DONE) && r_auto) begin
                    r_curFrame <= r_curFrame + {{(FRAME_SEL_BITS-1){1'b0}}, 1'b1};
                end
                if (SEL_VALID) begin
                    r_pendValid <= 1'b1;
                    r_pendFrame <= SEL_FRAME;
                    r_pendAuto  <= SEL_AUTO;
                end
            end
        end
    end

    assign SRC_EN    = w_run;
    assign SRC_ADDR  = w_run ? {r_copyFrame, w_wordIdx} : '0;
    assign DST_EN    = w_dstValid;
    assign DST_WE    = w_dstValid;
    assign DST_ADDR  = w_dstValid ? w_dstAddr : '0;
    assign DST_DATA  = w_dstValid ? SRC_DATA : 16'h0000;
    assign CUR_FRAME = r_curFrame;
    assign SKIP_CNT  = r_skipCnt;

endmodule
`default_nettype wire

// File: doc/frame_blit_scheduler.md
FRAME_BLIT_SCHEDULER -- requirements
Module: frame_blit_scheduler

Interface
REQ-001 SHALL have parameters: FRAME_WORDS, 1024, words per frame; FRAME_SEL_BITS, 2, frame-select width (4 frames in a 4096x16 frame store).
REQ-002 SHALL have ports: CLK  in  1  system clock; one clock domain, all logic on the rising edge.
REQ-003 SHALL have ports: RESET  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: TICK_IRQ  in  1  timer tick request (level); TICK_IACK  out  1  tick acknowledge pulse; TICK_IEND  out  1  tick-service-end pulse.
REQ-005 SHALL have ports: SEL_VALID  in  1  frame-select strobe; SEL_FRAME  in  2  requested frame; SEL_AUTO  in  1  auto-advance enable, sampled with SEL_VALID.
REQ-006 SHALL have ports: SRC_EN  out  1  frame-store read enable; SRC_ADDR  out  12  read address; SRC_DATA  in  16  read data, valid one cycle after SRC_EN.
REQ-007 SHALL have ports: DST_EN  out  1  VRAM enable; DST_WE  out  1  VRAM write; DST_ADDR  out  10  VRAM address; DST_DATA  out  16  VRAM write data.
REQ-008 SHALL have ports: GPU_READY  in  1  GPU can accept a new frame; GPU_DRAW  out  1  one-cycle draw pulse.
REQ-009 SHALL have ports: BUSY  out  1  copy in progress; CUR_FRAME  out  2  frame that the next copy uses; SKIP_CNT  out  8  ticks dropped because the GPU was not ready.

Function
REQ-010 SHALL implement FSM states IDLE, ACK, COPY, DRAIN, DONE and SKIP.
REQ-011 IDLE: TICK_IRQ=1 SHALL go to ACK; otherwise stay in IDLE.
REQ-012 ACK SHALL pulse TICK_IACK for one cycle, then go to COPY if GPU_READY=1, else to SKIP.
REQ-013 On entry to COPY, the block SHALL latch CUR_FRAME into a copy-frame register; SEL_VALID events during the copy SHALL NOT alter that copy.
REQ-014 COPY SHALL last exactly FRAME_WORDS cycles; in cycle k (k=0..1023) it SHALL assert SRC_EN with SRC_ADDR = {copy_frame, k[9:0]}.
REQ-015 In the cycle after each read, DST_EN=DST_WE=1 with DST_ADDR=k and DST_DATA=SRC_DATA, giving one word per cycle, pipelined.
REQ-016 DRAIN SHALL be one cycle that writes word 1023 with no read issued; a whole copy therefore takes 1025 cycles from the first SRC_EN to the last DST_WE.
REQ-017 DONE SHALL, in one cycle, pulse GPU_DRAW and TICK_IEND, apply the frame update, and return to IDLE.
REQ-018 SKIP SHALL pulse TICK_IEND, increment SKIP_CNT (saturating at 255, no wrap), leave CUR_FRAME unchanged, and return to IDLE.
REQ-019 SEL_VALID=1 in any state SHALL store SEL_FRAME and SEL_AUTO in a pending register, last write wins; CUR_FRAME and the auto flag SHALL update from it in IDLE or in DONE.
REQ-020 Frame update in DONE: a pending select SHALL win over auto-advance; otherwise, if auto=1, CUR_FRAME SHALL increment modulo 4 (3 wraps to 0).
REQ-021 BUSY SHALL be 1 in ACK, COPY, DRAIN and DONE, and 0 in IDLE and SKIP.
REQ-022 In every cycle where the FSM does not drive SRC_*/DST_*, those outputs SHALL be 0, and DST_DATA SHALL be 0.
REQ-023 TICK_IRQ that is still high when the FSM returns to IDLE SHALL start a new service on the next cycle; no tick is queued beyond that level.

Reset
REQ-024 RESET=1 at a clock edge SHALL force IDLE, CUR_FRAME=0, auto=0, no pending select, SKIP_CNT=0, and every output 0, including mid-copy (the copy is abandoned with no GPU_DRAW and no TICK_IEND).
REQ-025 The first cycle after reset deasserts SHALL be in IDLE.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, FRAME_WORDS, FRAME_SEL_BITS and the 12-bit frame-store address width.
REQ-027 One sub-module SHALL be used: blit_addr_gen, a 10-bit word counter with a terminal-count flag and a one-cycle-delayed copy for DST_ADDR.

Verification
REQ-028 Reset, frame-store word i = {frame, i}, GPU_READY=1, one TICK_IRQ pulse -> TICK_IACK one cycle later, 1024 writes to VRAM with VRAM[i]=i, one GPU_DRAW, one TICK_IEND, CUR_FRAME=0.
REQ-029 SEL_VALID with SEL_FRAME=2 and SEL_AUTO=1, then 3 ticks -> copies from frames 2, 3 and 0 (wrap), with SRC_ADDR starting at 0x800, 0xC00 and 0x000.
REQ-030 GPU_READY=0 on 300 ticks -> 300 TICK_IEND pulses, no DST_WE, no GPU_DRAW, SKIP_CNT=255.
REQ-031 SEL_VALID with SEL_FRAME=1 in the middle of a copy of frame 0 -> the current copy stays on frame 0; DONE sets CUR_FRAME=1 even with auto=1.
REQ-032 RESET asserted at copy word 500 -> all outputs 0 on the next cycle, no GPU_DRAW; a following tick copies frame 0 from word 0.
